traffic_ctrl_param: RTL
=======================

# traffic_ctrl_param

Parametrised two-road traffic-light controller. Successor to the fixed-duration lab controller: it adds programmable phase durations, a separate all-red clearance phase, a pedestrian-request shortening of green, blinking-yellow night mode, and a pause input. It runs on the system clock with a single-cycle `tick` enable from a `freq_div` strobe, and feeds the light LEDs, the 7-seg digit mux (two BCD digits), and the dot-matrix walker (`man_mode`).

## Interface

- `GREEN_T`, 20: green duration in ticks, 1..99.
- `YELLOW_T`, 3: yellow duration in ticks, 1..99.
- `ALLRED_T`, 2: all-red clearance in ticks, 1..99.
- `MIN_GREEN`, 5: green remainder after a pedestrian request, 1..GREEN_T.
- `NIGHT_HALF`, 1: ticks per night blink half-period, 1..99.
- `clk`, in, 1: system clock. Single clock domain.
- `reset`, in, 1: synchronous, active-high.
- `tick`, in, 1: one-`clk` strobe. All timing advances only on `tick & enable`.
- `enable`, in, 1: 0 freezes state, timer and blink phase.
- `nightcomes`, in, 1: night-mode request, level.
- `ped_req`, in, 1: pedestrian button, level, sampled every `clk`.
- `EW_lights`, out, 3: {g,y,r} for the east–west road.
- `NS_lights`, out, 3: {g,y,r} for the north–south road.
- `cnt_tens`, out, 4: BCD tens digit of the remaining ticks.
- `cnt_ones`, out, 4: BCD ones digit of the remaining ticks.
- `disp_blank`, out, 1: 1 in NIGHT; the 7-seg must be blanked.
- `man_mode`, out, 2: 00 green walker, 01 red walker, 10 night symbol.
- `ped_wait`, out, 1: a pedestrian request is pending.

## Operation

- States: GREEN, YELLOW, ALLRED, NIGHT. The `side` bit selects the road: `side=1` means EW is the active road.
- Timer:
  - Held as two BCD digits, {tens, ones}.
  - On each advancing tick it decrements with a borrow: ones 0 becomes 9 and tens decrements.
  - A phase ends on the advancing tick where the timer equals 01. On that tick the next state is entered and the timer loads that state's duration.
- Transitions:
  - GREEN → YELLOW.
  - YELLOW → ALLRED.
  - ALLRED → GREEN, with `side` toggled and `ped_wait` cleared.
- Lights:
  - GREEN: active road 100, other road 001.
  - YELLOW: active road 010, other road 001.
  - ALLRED: both 001.
  - NIGHT: both 010 when blink phase = 1, both 000 when blink phase = 0.
- `man_mode`: 00 in GREEN, 01 in YELLOW and ALLRED, 10 in NIGHT.
- Pedestrian request:
  - `ped_req=1` on any `clk` sets `ped_wait`, unless the state is NIGHT (ignored there).
  - On an advancing tick in GREEN with `ped_wait=1` and timer > `MIN_GREEN`, the timer loads `MIN_GREEN` instead of decrementing.
- Night mode:
  - Entry: an advancing tick in GREEN, YELLOW or ALLRED with `nightcomes=1` → NIGHT. The timer loads `NIGHT_HALF`, blink phase is set to 1, and `ped_wait` is cleared.
  - In NIGHT, each end-of-period tick toggles the blink phase and reloads `NIGHT_HALF`.
  - Exit: only at an end-of-period tick with `nightcomes=0` → GREEN, with `side=1`, timer = `GREEN_T`, blink phase = 0.
- Priority on one advancing tick, highest first: night entry > phase end > pedestrian shortening > decrement.
- `cnt_tens`/`cnt_ones` always mirror the timer registers. In NIGHT they mirror the blink timer, while `disp_blank` is 1.

## Timing

- All state, timer, `side`, blink and `ped_wait` are registers. Outputs are a combinational decode of registers only; there is no input-to-output combinational path.
- Latency: `tick` at edge n takes effect in the outputs after edge n (visible in cycle n+1).
- `ped_req` to `ped_wait` is 1 cycle.
- Reset values:
  - State GREEN, `side=1`, timer = `GREEN_T`, blink phase 0, `ped_wait=0`.
  - Outputs: `EW_lights=100`, `NS_lights=001`, `man_mode=00`, `disp_blank=0`.
- Reset wins over every input, including `tick`, on the same edge. Reset asserted mid-phase returns to the reset values at the next edge.
- `tick` with `enable=0`: no change, except that `ped_wait` may still set.
- `tick` held high for k cycles counts as k ticks.
- A duration of 1 means the phase lasts exactly one tick.

## Test plan

- Parameters: `GREEN_T=5`, `YELLOW_T=2`, `ALLRED_T=1`, `MIN_GREEN=2`, `NIGHT_HALF=1`. One `tick` every 4 `clk`.
- **Reset and normal cycle.** Release reset, then issue 8 ticks.
  - Display sequence: 05,04,03,02,01 (EW 100 / NS 001), then 02,01 (EW 010), then 01 (both 001).
  - Then GREEN with NS 100 / EW 001 and display 05.
- **Pedestrian shortening.** Pulse `ped_req` at display 05.
  - `ped_wait=1` next cycle.
  - Next tick: display 02, then 01, then YELLOW.
  - `ped_wait` stays 1 until the ALLRED→GREEN edge, then 0.
- **Night entry and blink.** Hold `nightcomes=1` and tick during YELLOW.
  - `disp_blank=1`, `man_mode=10`, both roads 010.
  - Lights then alternate 000/010 on every tick.
- **Night exit.** Drop `nightcomes`.
  - Exit occurs at the next end-of-period tick.
  - Result: GREEN, EW 100, display 05.
- **Pause and reset.** Hold `enable=0` for 10 ticks: outputs frozen. Then assert `reset` for one cycle on the same edge as a `tick` at display 03: next cycle is display 05, EW 100, `ped_wait=0`.
- **Priority.** In GREEN at display 03, raise `nightcomes` and `ped_req` before the same tick.
  - NIGHT is entered.
  - `ped_wait` is 1 only until that tick's edge, then 0.

Source files
------------

// File: rtl/traffic_ctrl_param.sv
// Two-road traffic-light controller with programmable BCD phase timers,
// all-red clearance, pedestrian shortening, night blink and pause.
module traffic_ctrl_param #(
  parameter int GREEN_T    = 20,
  parameter int YELLOW_T   = 3,
  parameter int ALLRED_T   = 2,
  parameter int MIN_GREEN  = 5,
  parameter int NIGHT_HALF = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       enable,
  input  logic       nightcomes,
  input  logic       ped_req,
  output logic [2:0] EW_lights,
  output logic [2:0] NS_lights,
  output logic [3:0] cnt_tens,
  output logic [3:0] cnt_ones,
  output logic       disp_blank,
  output logic [1:0] man_mode,
  output logic       ped_wait
);

  typedef enum logic [1:0] {
    S_GREEN,
    S_YELLOW,
    S_ALLRED,
    S_NIGHT
  } state_t;

  localparam logic [7:0] GREEN_BCD =
    {4'(GREEN_T / 10), 4'(GREEN_T % 10)};
  localparam logic [7:0] YELLOW_BCD =
    {4'(YELLOW_T / 10), 4'(YELLOW_T % 10)};
  localparam logic [7:0] ALLRED_BCD =
    {4'(ALLRED_T / 10), 4'(ALLRED_T % 10)};
  localparam logic [7:0] MIN_BCD =
    {4'(MIN_GREEN / 10), 4'(MIN_GREEN % 10)};
  localparam logic [7:0] NIGHT_BCD =
    {4'(NIGHT_HALF / 10), 4'(NIGHT_HALF % 10)};
  localparam logic [6:0] MIN_BIN = 7'(MIN_GREEN);

  localparam logic [2:0] L_G   = 3'b100;
  localparam logic [2:0] L_Y   = 3'b010;
  localparam logic [2:0] L_R   = 3'b001;
  localparam logic [2:0] L_OFF = 3'b000;

  state_t     state_q, state_d;
  logic       side_q, side_d;
  logic [7:0] timer_q, timer_d;
  logic       blink_q, blink_d;
  logic       ped_q, ped_d;

  logic       adv;
  logic       at_end;
  logic [6:0] timer_bin;
  logic       long_green;
  logic [7:0] timer_dec;

  assign adv        = tick & enable;
  assign at_end     = (timer_q == 8'h01);
  assign timer_bin  = 7'(timer_q[7:4]) * 7'd10
                    + 7'(timer_q[3:0]);
  assign long_green = (timer_bin > MIN_BIN);

  // BCD borrow: ones wraps 0 -> 9 and takes one from tens
  always_comb begin
    if (timer_q[3:0] == 4'd0) begin
      timer_dec = {timer_q[7:4] - 4'd1, 4'd9};
    end else begin
      timer_dec = {timer_q[7:4], timer_q[3:0] - 4'd1};
    end
  end

  always_comb begin
    state_d = state_q;
    side_d  = side_q;
    timer_d = timer_q;
    blink_d = blink_q;
    ped_d   = ped_q;

    if (ped_req && state_q != S_NIGHT) begin
      ped_d = 1'b1;
    end

    if (adv) begin
      if (state_q != S_NIGHT && nightcomes) begin
        state_d = S_NIGHT;
        timer_d = NIGHT_BCD;
        blink_d = 1'b1;
        ped_d   = 1'b0;
      end else if (at_end) begin
        unique case (state_q)
          S_GREEN: begin
            state_d = S_YELLOW;
            timer_d = YELLOW_BCD;
          end
          S_YELLOW: begin
            state_d = S_ALLRED;
            timer_d = ALLRED_BCD;
          end
          S_ALLRED: begin
            state_d = S_GREEN;
            timer_d = GREEN_BCD;
            side_d  = ~side_q;
            ped_d   = 1'b0;
          end
          S_NIGHT: begin
            if (nightcomes) begin
              blink_d = ~blink_q;
              timer_d = NIGHT_BCD;
            end else begin
              state_d = S_GREEN;
              side_d  = 1'b1;
              timer_d = GREEN_BCD;
              blink_d = 1'b0;
            end
          end
          default: begin
            state_d = S_GREEN;
          end
        endcase
      end else if (state_q == S_GREEN && ped_q
                   && long_green) begin
        timer_d = MIN_BCD;
      end else begin
        timer_d = timer_dec;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_GREEN;
      side_q  <= 1'b1;
      timer_q <= GREEN_BCD;
      blink_q <= 1'b0;
      ped_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      side_q  <= side_d;
      timer_q <= timer_d;
      blink_q <= blink_d;
      ped_q   <= ped_d;
    end
  end

  // Output decode reads registers only
  logic [2:0] act_l;
  logic [2:0] oth_l;

  always_comb begin
    act_l      = L_R;
    oth_l      = L_R;
    man_mode   = 2'b01;
    disp_blank = 1'b0;
    unique case (state_q)
      S_GREEN: begin
        act_l    = L_G;
        man_mode = 2'b00;
      end
      S_YELLOW: begin
        act_l = L_Y;
      end
      S_ALLRED: begin
        act_l = L_R;
      end
      S_NIGHT: begin
        act_l      = blink_q ? L_Y : L_OFF;
        oth_l      = blink_q ? L_Y : L_OFF;
        man_mode   = 2'b10;
        disp_blank = 1'b1;
      end
      default: begin
        act_l = L_R;
      end
    endcase
  end

  assign EW_lights = side_q ? act_l : oth_l;
  assign NS_lights = side_q ? oth_l : act_l;
  assign cnt_tens  = timer_q[7:4];
  assign cnt_ones  = timer_q[3:0];
  assign ped_wait  = ped_q;

endmodule
